sipo_frame_rx: RTL and testbench

Serial-to-parallel frame receiver: the receiving end of the team's single-bit serial data path. It samples a framed serial stream (start bit, data bits LSB first, optional even parity, stop bit) on qualified clock edges, assembles the word, and presents it on a parallel bus with a one-cycle valid pulse and error flags. It sits downstream of any serial shift chain or serializer in the design and feeds parallel consumers.

---
 rtl/sipo_frame_rx.sv | 159 +++++++++++++++
 tb/tb_sipo_frame_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver.
// Samples start bit, DATA_WIDTH data bits (LSB first), an optional even
// parity bit and a stop bit on strobed clock edges. A good word is presented
// on data_out with a one-cycle data_valid pulse. Errors are reported as
// one-cycle pulses. Every output comes straight from a flop.
module sipo_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clock_in,
  input  logic                  resetn,
  input  logic                  serial_in,
  input  logic                  serial_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Even parity: 1 when the vector holds an odd number of ones.
  function automatic logic odd_ones(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                state_r;
  state_t                state_next_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_next_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_next_s;
  logic                  par_bit_r;
  logic                  par_bit_next_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] data_out_next_s;
  logic                  data_valid_r;
  logic                  data_valid_next_s;
  logic                  parity_err_r;
  logic                  parity_err_next_s;
  logic                  frame_err_r;
  logic                  frame_err_next_s;
  logic                  busy_r;
  logic                  busy_next_s;
  logic                  par_fail_s;

  // Parity failure: data bits XOR received parity bit must be 0.
  always_comb begin
    par_fail_s = 1'b0;
    if (PARITY_EN != 0) begin
      par_fail_s = odd_ones(shift_r) ^ par_bit_r;
    end else begin
      par_fail_s = 1'b0;
    end
  end

  // Next-state, datapath and pulse decode. Nothing moves without a strobe.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    shift_next_s      = shift_r;
    par_bit_next_s    = par_bit_r;
    data_out_next_s   = data_out_r;
    data_valid_next_s = 1'b0;
    parity_err_next_s = 1'b0;
    frame_err_next_s  = 1'b0;
    if (serial_en) begin
      case (state_r)
        ST_IDLE: begin
          if (!serial_in) begin
            state_next_s = ST_DATA;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift towards bit 0.
          shift_next_s = {serial_in, shift_r[DATA_WIDTH-1:1]};
          cnt_next_s   = cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_next_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            state_next_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_bit_next_s = serial_in;
          state_next_s   = ST_STOP;
        end
        ST_STOP: begin
          // A 0 stop bit is a framing error, not a new start bit.
          if (serial_in) begin
            data_out_next_s   = shift_r;
            data_valid_next_s = 1'b1;
            parity_err_next_s = par_fail_s;
          end else begin
            frame_err_next_s  = 1'b1;
          end
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      cnt_r        <= {CW{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      par_bit_r    <= 1'b0;
      data_out_r   <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      shift_r      <= shift_next_s;
      par_bit_r    <= par_bit_next_s;
      data_out_r   <= data_out_next_s;
      data_valid_r <= data_valid_next_s;
      parity_err_r <= parity_err_next_s;
      frame_err_r  <= frame_err_next_s;
      busy_r       <= busy_next_s;
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx: one instance with parity, one without.
// The driver builds frames and queues expected results; a negedge monitor
// pops and compares whenever an instance pulses.
module tb_sipo_frame_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       ser0;
  logic       ser1;
  logic       en;
  logic [7:0] d0_out;
  logic       d0_dv;
  logic       d0_pe;
  logic       d0_fe;
  logic       d0_busy;
  logic [7:0] d1_out;
  logic       d1_dv;
  logic       d1_pe;
  logic       d1_fe;
  logic       d1_busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_good[2];
  int   bstart[2];
  int   bend[2];

  sipo_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(1)) dut0 (
    .clock_in(clk), .resetn(resetn), .serial_in(ser0), .serial_en(en),
    .data_out(d0_out), .data_valid(d0_dv), .parity_err(d0_pe),
    .frame_err(d0_fe), .busy(d0_busy)
  );

  sipo_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(0)) dut1 (
    .clock_in(clk), .resetn(resetn), .serial_in(ser1), .serial_en(en),
    .data_out(d1_out), .data_valid(d1_dv), .parity_err(d1_pe),
    .frame_err(d1_fe), .busy(d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc_cnt);
    end
  endtask

  // Monitor for one instance, called on every falling edge.
  task automatic mon(input int d, input logic [7:0] dout, input logic dv,
                     input logic pe, input logic fe, input logic bz);
    exp_t e;
    logic have;
    string nm;
    nm = (d == 0) ? "p1" : "p0";
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    e = '0;
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (!resetn) begin
      last_good[d] = 8'h00;
      check({nm, "_rst_outs"}, 32'({dout, dv, pe, fe, bz}), 32'd0);
      return;
    end
    check({nm, "_busy"}, 32'(bz), 32'((cyc_cnt >= bstart[d]) && (cyc_cnt < bend[d])));
    if (dv || fe) begin
      check({nm, "_dv_fe_excl"}, 32'(dv && fe), 32'd0);
      if (!have) begin
        check({nm, "_unexpected_pulse"}, 32'({dv, fe}), 32'd0);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check({nm, "_pulse_cycle"}, 32'(cyc_cnt), 32'(e.cyc));
        check({nm, "_fe"}, 32'(fe), 32'(e.fe));
        check({nm, "_dv"}, 32'(dv), 32'(!e.fe));
        check({nm, "_pe"}, 32'(pe), 32'(e.pe));
        if (!e.fe) last_good[d] = e.data;
        check({nm, "_data"}, 32'(dout), 32'(last_good[d]));
      end
    end else begin
      if (pe) check({nm, "_pe_alone"}, 32'(pe), 32'd0);
      if (dout !== last_good[d]) check({nm, "_data_hold"}, 32'(dout), 32'(last_good[d]));
      if (have && cyc_cnt >= e.cyc) begin
        check({nm, "_missed_pulse"}, 32'd0, 32'd1);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, d0_out, d0_dv, d0_pe, d0_fe, d0_busy);
    mon(1, d1_out, d1_dv, d1_pe, d1_fe, d1_busy);
  end

  // Drive one line bit on a strobe, preceded by gap-1 unstrobed cycles.
  task automatic send_bit(input int d, input logic b, input int gap);
    for (int g = 1; g < gap; g++) begin
      @(negedge clk);
      en   = 1'b0;
      ser0 = 1'($urandom_range(0, 1));
      ser1 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    en   = 1'b1;
    ser0 = (d == 0) ? b : 1'b1;
    ser1 = (d == 1) ? b : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en   = 1'($urandom_range(0, 1));
      ser0 = 1'b1;
      ser1 = 1'b1;
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic bad_par,
                            input logic bad_stop, input int gap);
    exp_t e;
    logic pbit;
    int   ones;
    ones = $countones(data);
    pbit = ((ones % 2) == 1) ^ bad_par;
    send_bit(d, 1'b0, gap);
    bend[d]   = 1 << 30;
    bstart[d] = cyc_cnt + 1;
    for (int i = 0; i < 8; i++) send_bit(d, data[i], gap);
    if (d == 0) send_bit(d, pbit, gap);
    send_bit(d, !bad_stop, gap);
    bend[d] = cyc_cnt + 1;
    e.cyc  = cyc_cnt + 1;
    e.data = data;
    e.fe   = bad_stop;
    e.pe   = (d == 0) && !bad_stop && (((ones + int'(pbit)) % 2) == 1);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    ser0   = 1'b1;
    ser1   = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    bstart[0] = 0; bstart[1] = 0;
    bend[0]   = 0; bend[1]   = 0;
    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(d0_out), 32'd0);
    #2 resetn = 1'b1;
    idle(3);

    // Nominal 0xA5, then bad parity, then frame-error sequence.
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1);
    idle(2);
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1);
    idle(2);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
    idle(1);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1);
    idle(2);
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1);
    idle(2);
    // Gapped strobe.
    send_frame(0, 8'h81, 1'b0, 1'b0, 3);
    idle(3);
    // Back-to-back without parity.
    send_frame(1, 8'h12, 1'b0, 1'b0, 1);
    send_frame(1, 8'h34, 1'b0, 1'b0, 1);
    idle(3);

    // Reset in the middle of 0xFF after four data bits.
    send_bit(0, 1'b0, 1);
    bend[0] = 1 << 30;
    bstart[0] = cyc_cnt + 1;
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1);
    @(negedge clk);
    en = 1'b0; ser0 = 1'b1; ser1 = 1'b1;
    #2 resetn = 1'b0;
    bend[0] = 0;
    #1 check("midreset_outs", 32'({d0_out, d0_dv, d0_pe, d0_fe, d0_busy}), 32'd0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    idle(6);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1);
    idle(2);

    // Randomized frames on both instances.
    for (int n = 0; n < 40; n++) begin
      send_frame(n % 2, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0),
                 $urandom_range(1, 3));
      idle($urandom_range(0, 2));
    end

    idle(20);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
